fifo_rd_prefetch: RTL
=====================

FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 SHALL have parameter N_log, default 8, meaning FIFO pointer width (carried for integration consistency only).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 SHALL use one clock, clk_rd; reset rst_rd is asynchronous and active-high.
REQ-004 clk_rd  input  1  read-side clock; all state on its rising edge.
REQ-005 rst_rd  input  1  asynchronous active-high reset.
REQ-006 i_fifo_empty  input  1  registered empty flag of the FIFO pointer logic.
REQ-007 o_fifo_advance  output  1  pops one FIFO word this cycle.
REQ-008 i_ram_data  input  DATA_W  FIFO RAM read data; holds the word popped by o_fifo_advance in the previous cycle.
REQ-009 o_valid  output  1  o_data holds a valid word.
REQ-010 i_ready  input  1  consumer accepts o_data this cycle.
REQ-011 o_data  output  DATA_W  head word of the prefetch buffer.
REQ-012 o_level  output  2  number of words held in the prefetch buffer, 0..3.

Function
REQ-013 SHALL hold a 3-entry circular buffer: wr_idx, rd_idx (each 0..2, wrapping 2->0), cnt (0..3) and pending flag pend_q.
REQ-014 o_fifo_advance SHALL equal ~i_fifo_empty & ((cnt + pend_q) < 3); it SHALL NOT depend on i_ready.
REQ-015 pend_q SHALL register o_fifo_advance every cycle.
REQ-016 When pend_q=1, i_ram_data SHALL be written to entry wr_idx and wr_idx SHALL advance by one with wrap.
REQ-017 pop = o_valid & i_ready; on pop rd_idx SHALL advance by one with wrap.
REQ-018 cnt_next SHALL be cnt + pend_q - pop; simultaneous write and pop SHALL leave cnt unchanged.
REQ-019 o_valid SHALL be (cnt != 0); o_data SHALL be entry rd_idx, driven from registers only (no bypass of i_ram_data).
REQ-020 o_level SHALL equal cnt.
REQ-021 Latency: with cnt=0 and pend_q=0, a word popped in cycle T SHALL appear on o_data with o_valid=1 in cycle T+2.
REQ-022 Throughput: with FIFO never empty and i_ready held at 1, one word per cycle SHALL be delivered in steady state.
REQ-023 Full: at cnt + pend_q = 3, o_fifo_advance SHALL be 0 regardless of i_ready; cnt SHALL never exceed 3 and no entry SHALL be overwritten before it is popped.
REQ-024 Empty: i_ready with o_valid=0 SHALL have no effect (no underflow, rd_idx held).
REQ-025 Words SHALL exit in exact FIFO pop order; o_data SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-026 While rst_rd=1: cnt=0, pend_q=0, wr_idx=0, rd_idx=0; outputs o_valid=0, o_level=0, o_fifo_advance=0.
REQ-027 Buffer entry contents SHALL NOT be reset; o_data is don't-care while o_valid=0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight words; the FIFO pointer logic is reset in the same cycle by integration.
REQ-029 After rst_rd deasserts, operation SHALL start on the first clk_rd edge with i_fifo_empty=0.

Verification
REQ-030 Single word: i_fifo_empty low for 1 cycle at T, word 0xA5A5A5A5, i_ready=1 -> o_fifo_advance=1 at T, o_valid=1 with o_data=0xA5A5A5A5 at T+2, o_valid=0 at T+3.
REQ-031 Backpressure fill: FIFO holds 10 words, i_ready=0 -> exactly 3 advances, o_level=3, o_fifo_advance stays 0; raising i_ready drains words 0..9 in order.
REQ-032 Streaming: FIFO holds 100 words 0..99, i_ready=1 -> after the 2-cycle fill latency, 100 consecutive cycles with o_valid=1 and data 0..99.
REQ-033 Random i_ready (50%), random empty gaps, 10,000 words -> scoreboard matches order, cnt never exceeds 3, no advance while i_fifo_empty=1.
REQ-034 Reset mid-stream: assert rst_rd with o_level=2 and pend_q=1 -> o_valid=0 and o_level=0 immediately; after release, the first word output equals the first word written post-reset.
REQ-035 Wrap: deliver 7 words with one-cycle pops interleaved -> rd_idx/wr_idx wrap 2->0 with no data corruption.

Source files
------------

// File: rtl/fifo_rd_prefetch.sv
// fifo_rd_prefetch: 3-entry prefetch buffer between a FIFO RAM read port and a valid/ready consumer
module fifo_rd_prefetch #(
  parameter int N_log = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_rd,
  input  logic              rst_rd,
  input  logic              i_fifo_empty,
  output logic              o_fifo_advance,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_level
);
  if (N_log < 1) begin : g_nlog_invalid
  end
  logic [DATA_W-1:0] mem [0:2];
  logic [1:0] wr_idx, rd_idx, cnt;
  logic pend_q, pop;
  logic [2:0] occ;
  always_comb begin
    occ = {1'b0, cnt} + {2'b0, pend_q};
    o_fifo_advance = ~rst_rd & ~i_fifo_empty & (occ < 3'd3);
    o_valid = cnt != 2'd0;
    pop = o_valid & i_ready;
    o_data = mem[rd_idx];
    o_level = cnt;
  end
  always_ff @(posedge clk_rd or posedge rst_rd) begin
    if (rst_rd) begin
      cnt <= 2'd0;
      pend_q <= 1'b0;
      wr_idx <= 2'd0;
      rd_idx <= 2'd0;
    end else begin
      pend_q <= o_fifo_advance;
      if (pend_q) wr_idx <= (wr_idx == 2'd2) ? 2'd0 : wr_idx + 2'd1;
      if (pop) rd_idx <= (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
      cnt <= cnt + {1'b0, pend_q} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk_rd) begin
    if (pend_q) mem[wr_idx] <= i_ram_data;
  end
endmodule
